// File: rtl/raggedstone_spinn_aer_if_pkg.sv
// raggedstone_spinn_aer_if_pkg: shared mode constants and FSM encoding for the AER interface UI
package raggedstone_spinn_aer_if_pkg;
  localparam int CNT_BITS = 24;
  localparam int MODE_BITS_DEF = 2;
  localparam int NUM_MODES_DEF = 4;
  localparam int DEFAULT_MODE_DEF = 0;
  localparam logic [CNT_BITS-1:0] LONG_CONST_DEF = 24'hffffff;
  typedef enum logic [2:0] {
    IDLE,
    HELD_NEXT,
    HELD_PREV,
    HELD_LONG,
    HELD_BOTH,
    REQ
  } state_t;
endpackage

// File: rtl/raggedstone_spinn_aer_if_press_timer.sv
// raggedstone_spinn_aer_if_press_timer: button edge detect and saturating hold counter
module raggedstone_spinn_aer_if_press_timer
  import raggedstone_spinn_aer_if_pkg::*;
#(
  parameter logic [CNT_BITS-1:0] LONG_CONST = LONG_CONST_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pb_n,
  output logic press,
  output logic rel,
  output logic held_long
);
  logic                pb_q;
  logic [CNT_BITS-1:0] cnt;
  // previous button level and cycles held low, saturating at LONG_CONST
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pb_q <= 1'b1;
      cnt  <= '0;
    end else begin
      pb_q <= pb_n;
      cnt  <= pb_n ? '0 : (cnt == LONG_CONST ? cnt : cnt + 1'b1);
    end
  end
  // long fires once, on the cycle the hold reaches LONG_CONST cycles
  always_comb begin
    press     = pb_q & ~pb_n;
    rel       = ~pb_q & pb_n;
    held_long = ~pb_n & (cnt == LONG_CONST - 1'b1);
  end
endmodule

// File: rtl/raggedstone_spinn_aer_if_mode_ctrl.sv
// raggedstone_spinn_aer_if_mode_ctrl: push-button mode sequencer with req/ack mode handshake
module raggedstone_spinn_aer_if_mode_ctrl
  import raggedstone_spinn_aer_if_pkg::*;
#(
  parameter int                  NUM_MODES    = NUM_MODES_DEF,
  parameter int                  MODE_BITS    = MODE_BITS_DEF,
  parameter int                  DEFAULT_MODE = DEFAULT_MODE_DEF,
  parameter logic [CNT_BITS-1:0] LONG_CONST   = LONG_CONST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pb_next_n,
  input  logic                 pb_prev_n,
  output logic                 chg_req,
  output logic [MODE_BITS-1:0] chg_mode,
  input  logic                 chg_ack,
  output logic [MODE_BITS-1:0] mode,
  output logic                 mode_changed
);
  localparam logic [MODE_BITS-1:0] DEF_M = MODE_BITS'(DEFAULT_MODE);
  localparam logic [MODE_BITS-1:0] TOP_M = MODE_BITS'(NUM_MODES - 1);
  state_t               state, state_nxt;
  logic                 n_press, n_rel, n_long, p_press, p_rel, p_long;
  logic                 btn_idle, req_set, ack_hit;
  logic [MODE_BITS-1:0] req_mode;
  raggedstone_spinn_aer_if_press_timer #(.LONG_CONST(LONG_CONST)) u_next (
    .clk(clk), .rst(rst), .pb_n(pb_next_n), .press(n_press), .rel(n_rel), .held_long(n_long)
  );
  raggedstone_spinn_aer_if_press_timer #(.LONG_CONST(LONG_CONST)) u_prev (
    .clk(clk), .rst(rst), .pb_n(pb_prev_n), .press(p_press), .rel(p_rel), .held_long(p_long)
  );
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // next state: a second press aborts, a long hold wins over release, REQ waits for ack and idle buttons
  always_comb begin
    btn_idle  = pb_next_n & pb_prev_n;
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = (n_press & p_press) ? HELD_BOTH : n_press ? HELD_NEXT : p_press ? HELD_PREV : IDLE;
      HELD_NEXT: state_nxt = p_press ? HELD_BOTH : n_long ? HELD_LONG : n_rel ? REQ : HELD_NEXT;
      HELD_PREV: state_nxt = n_press ? HELD_BOTH : p_long ? HELD_LONG : p_rel ? REQ : HELD_PREV;
      HELD_LONG: state_nxt = btn_idle ? REQ : HELD_LONG;
      HELD_BOTH: state_nxt = btn_idle ? IDLE : HELD_BOTH;
      REQ:       state_nxt = (~chg_req & btn_idle) ? IDLE : REQ;
      default:   state_nxt = IDLE;
    endcase
  end
  // request target: step with explicit wrap, or default after a long hold
  always_comb begin
    req_set  = (state != REQ) & (state_nxt == REQ);
    ack_hit  = chg_req & chg_ack;
    req_mode = state == HELD_NEXT ? (mode == TOP_M ? '0 : mode + 1'b1) :
               state == HELD_PREV ? (mode == '0 ? TOP_M : mode - 1'b1) : DEF_M;
  end
  // handshake registers: chg_mode frozen while requesting, mode applied on ack
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_req      <= 1'b0;
      chg_mode     <= DEF_M;
      mode         <= DEF_M;
      mode_changed <= 1'b0;
    end else begin
      chg_req      <= req_set | (chg_req & ~chg_ack);
      chg_mode     <= req_set ? req_mode : chg_mode;
      mode         <= ack_hit ? chg_mode : mode;
      mode_changed <= ack_hit;
    end
  end
endmodule
